// File: rtl/jtframe_snd_sddac_pkg.sv
// Shared constants and helpers for the stereo sigma-delta audio output stage.
package jtframe_snd_sddac_pkg;

    localparam int ACC_W = 24;
    localparam int PCM_W = 20;

    localparam logic signed [ACC_W-1:0] FS = 24'sh080000;

    // Offset-binary sample placed below the full-scale bit: range 0..0x7FFF8.
    function automatic logic [PCM_W-1:0] snd_pad(input logic [15:0] snd, input logic signed_flag);
        return {1'b0, snd[15] ^ signed_flag, snd[14:0], 3'b000};
    endfunction

    function automatic logic signed [ACC_W-1:0] sat24(input logic signed [ACC_W+1:0] v);
        if (v > 26'sd8388607)
            return 24'sh7FFFFF;
        else if (v < -26'sd8388608)
            return 24'sh800000;
        else
            return v[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/jtframe_snd_sddac_sd2_modulator.sv
// Second-order 1-bit sigma-delta modulator with saturating integrators.
module jtframe_snd_sddac_sd2_modulator
    import jtframe_snd_sddac_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic [PCM_W-1:0] pcm,
    output logic             q
);

    logic signed [ACC_W-1:0] i1, i2, i1n, i2n, fb;
    logic signed [ACC_W+1:0] s1, s2;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        fb  = q ? FS : '0;
        s1  = (ACC_W+2)'(i1) + $signed({{(ACC_W+2-PCM_W){1'b0}}, pcm}) - (ACC_W+2)'(fb);
        i1n = sat24(s1);
        s2  = (ACC_W+2)'(i2) + (ACC_W+2)'(i1n) - (ACC_W+2)'(fb);
        i2n = sat24(s2);
    end

    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i1 <= '0;
            i2 <= '0;
            q  <= 1'b0;
        end else if (cen) begin
            i1 <= i1n;
            i2 <= i2n;
            q  <= ~i2n[ACC_W-1];
        end
    end

endmodule

// File: rtl/jtframe_snd_sddac.sv
// Stereo 1-bit audio output: divide-by-4 enable, sample formatting, sigma-delta per channel.
module jtframe_snd_sddac
    import jtframe_snd_sddac_pkg::*;
#(
    parameter logic SIGNED_SND = 1'b0,
    parameter logic STEREO     = 1'b0
) (
    input  logic        clk_dac,
    input  logic        rst,
    input  logic [15:0] snd_left,
    input  logic [15:0] snd_right,
    output logic        snd_pwm_left,
    output logic        snd_pwm_right,
    output logic        cen_dac
);

    logic [3:0]       sr;
    logic [PCM_W-1:0] pcm_left, pcm_right;
    logic             q_left;

    // One-hot ring: the enable lands on the 2nd edge after release, then every 4th.
    always_ff @(posedge clk_dac or posedge rst) begin
        if (rst) sr <= 4'b0100;
        else     sr <= {sr[2:0], sr[3]};
    end

    assign cen_dac   = sr[0];
    assign pcm_left  = snd_pad(snd_left,  SIGNED_SND);
    assign pcm_right = snd_pad(snd_right, SIGNED_SND);

    jtframe_snd_sddac_sd2_modulator u_left (
        .clk (clk_dac),
        .rst (rst),
        .cen (cen_dac),
        .pcm (pcm_left),
        .q   (q_left)
    );

    assign snd_pwm_left = q_left;

    generate
        if (STEREO) begin : g_stereo
            logic q_right;

            jtframe_snd_sddac_sd2_modulator u_right (
                .clk (clk_dac),
                .rst (rst),
                .cen (cen_dac),
                .pcm (pcm_right),
                .q   (q_right)
            );

            assign snd_pwm_right = q_right;
        end else begin : g_mono
            // The right pcm path is unused in mono builds.
            logic unused_right;
            assign unused_right  = ^pcm_right;
            assign snd_pwm_right = q_left;
        end
    endgenerate

endmodule

// File: tb/tb_jtframe_snd_sddac.sv
// Scoreboard bench: one signed/mono and one unsigned/stereo instance against an arithmetic model.
module tb_jtframe_snd_sddac;

    logic        clk_dac = 1'b0;
    logic        rst     = 1'b1;
    logic [15:0] a_snd_l = '0, a_snd_r = '0, b_snd_l = '0, b_snd_r = '0;
    logic        a_pwm_l, a_pwm_r, a_cen, b_pwm_l, b_pwm_r, b_cen;

    always #5 clk_dac = ~clk_dac;

    jtframe_snd_sddac #(.SIGNED_SND(1'b1), .STEREO(1'b0)) dut_a (
        .clk_dac       (clk_dac),
        .rst           (rst),
        .snd_left      (a_snd_l),
        .snd_right     (a_snd_r),
        .snd_pwm_left  (a_pwm_l),
        .snd_pwm_right (a_pwm_r),
        .cen_dac       (a_cen)
    );

    jtframe_snd_sddac #(.SIGNED_SND(1'b0), .STEREO(1'b1)) dut_b (
        .clk_dac       (clk_dac),
        .rst           (rst),
        .snd_left      (b_snd_l),
        .snd_right     (b_snd_r),
        .snd_pwm_left  (b_pwm_l),
        .snd_pwm_right (b_pwm_r),
        .cen_dac       (b_cen)
    );

    typedef struct packed {
        logic cen;
        logic upd;
        logic al;
        logic bl;
        logic br;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] trace_q[$];
    logic [2:0] fresh_trace[$];
    bit         record_trace = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int ones_al = 0, ones_bl = 0, ones_br = 0;

    // Reference model: edge counter since reset and per-channel integrators as plain integers.
    int     n_edges = 0;
    longint mi1[3];
    longint mi2[3];
    bit     mq[3];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        n_checks++;
        if (val < lo || val > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
        end
    endtask

    function automatic longint pcm_of(input logic [15:0] s, input bit is_signed);
        if (is_signed) return (longint'($signed(s)) + 32768) * 8;
        else           return longint'(s) * 8;
    endfunction

    function automatic longint clamp(input longint v);
        if (v > 8388607)  return 8388607;
        if (v < -8388608) return -8388608;
        return v;
    endfunction

    task automatic model_edge(input bit in_rst, output bit upd);
        exp_t   e;
        longint pcm, fb;
        upd = 1'b0;
        if (in_rst) begin
            n_edges = 0;
            for (int ch = 0; ch < 3; ch++) begin
                mi1[ch] = 0;
                mi2[ch] = 0;
                mq[ch]  = 1'b0;
            end
        end else begin
            upd = (n_edges % 4 == 2);
            if (upd) begin
                for (int ch = 0; ch < 3; ch++) begin
                    pcm = (ch == 0) ? pcm_of(a_snd_l, 1'b1) :
                          (ch == 1) ? pcm_of(b_snd_l, 1'b0) : pcm_of(b_snd_r, 1'b0);
                    fb  = mq[ch] ? 524288 : 0;
                    mi1[ch] = clamp(mi1[ch] + pcm - fb);
                    mi2[ch] = clamp(mi2[ch] + mi1[ch] - fb);
                    mq[ch]  = (mi2[ch] >= 0);
                end
            end
            n_edges++;
        end
        e.cen = !in_rst && (n_edges % 4 == 2);
        e.upd = upd;
        e.al  = mq[0];
        e.bl  = mq[1];
        e.br  = mq[2];
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per clock edge and compares it to the DUT.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_dac);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cen_a", 32'(a_cen), 32'(e.cen));
                check("cen_b", 32'(b_cen), 32'(e.cen));
                check("a_left", 32'(a_pwm_l), 32'(e.al));
                check("a_right_mono", 32'(a_pwm_r), 32'(e.al));
                check("b_left", 32'(b_pwm_l), 32'(e.bl));
                check("b_right", 32'(b_pwm_r), 32'(e.br));
                if (e.upd) begin
                    ones_al += int'(a_pwm_l);
                    ones_bl += int'(b_pwm_l);
                    ones_br += int'(b_pwm_r);
                    if (record_trace) trace_q.push_back({a_pwm_l, b_pwm_l, b_pwm_r});
                end
            end
        end
    end

    task automatic clear_counts();
        ones_al = 0;
        ones_bl = 0;
        ones_br = 0;
    endtask

    task automatic run_enables(input int n, input bit rand_a);
        int done = 0;
        bit upd;
        while (done < n) begin
            @(negedge clk_dac);
            rst     = 1'b0;
            a_snd_r = 16'($urandom);
            if (rand_a) a_snd_l = 16'($urandom);
            model_edge(1'b0, upd);
            if (upd) done++;
        end
        @(posedge clk_dac);
        #2;
    endtask

    task automatic do_reset(input int cycles);
        bit upd;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk_dac);
            rst = 1'b1;
            #1;
            if (c == 0) begin
                check("rst_a_left", 32'(a_pwm_l), 32'h0);
                check("rst_a_right", 32'(a_pwm_r), 32'h0);
                check("rst_b_left", 32'(b_pwm_l), 32'h0);
                check("rst_b_right", 32'(b_pwm_r), 32'h0);
                check("rst_cen", 32'(a_cen), 32'h0);
                check("rst_ring", 32'(dut_a.sr), 32'h4);
                check("rst_i2", {8'h0, dut_a.u_left.i2}, 32'h0);
            end
            model_edge(1'b1, upd);
        end
    endtask

    initial begin
        int mism;
        #1;
        check("init_left", 32'(a_pwm_l), 32'h0);
        check("init_right", 32'(b_pwm_r), 32'h0);
        check("init_cen", 32'(a_cen), 32'h0);
        do_reset(3);

        // Mid-scale on dut_a, 25% / 75% on dut_b; first 64 enables are recorded for replay.
        a_snd_l = 16'h0000;
        b_snd_l = 16'h4000;
        b_snd_r = 16'hC000;
        clear_counts();
        record_trace = 1'b1;
        run_enables(64, 1'b0);
        record_trace = 1'b0;
        fresh_trace = trace_q;
        trace_q.delete();
        check("first5_a_left",
              32'({fresh_trace[0][2], fresh_trace[1][2], fresh_trace[2][2],
                   fresh_trace[3][2], fresh_trace[4][2]}), 32'b10100);
        run_enables(4096 - 64, 1'b0);
        check_range("density_a_half", ones_al, 2040, 2056);
        check_range("density_b_l25", ones_bl, 1003, 1045);
        check_range("density_b_r75", ones_br, 3051, 3093);

        // Reset mid-stream for one cycle, then replay must match the fresh run.
        do_reset(1);
        record_trace = 1'b1;
        run_enables(64, 1'b0);
        record_trace = 1'b0;
        check("replay_len", 32'(trace_q.size()), 32'd64);
        mism = 0;
        for (int i = 0; i < 64 && i < trace_q.size(); i++)
            if (trace_q[i] !== fresh_trace[i]) mism++;
        check("replay_mismatches", 32'(mism), 32'd0);
        trace_q.delete();

        // Zero input from reset on dut_a; 75% / 25% on dut_b.
        do_reset(1);
        a_snd_l = 16'h8000;
        b_snd_l = 16'hC000;
        b_snd_r = 16'h4000;
        clear_counts();
        run_enables(4096, 1'b0);
        check("zero_ones_a", 32'(ones_al), 32'd1);
        check("zero_i2_clamp", {8'h0, dut_a.u_left.i2}, 32'h0080_0000);
        check_range("density_b_l75", ones_bl, 3051, 3093);
        check_range("density_b_r25", ones_br, 1003, 1045);

        // Step both dut_b channels; random samples on dut_a.
        b_snd_l = 16'h4000;
        b_snd_r = 16'hC000;
        run_enables(64, 1'b1);
        clear_counts();
        run_enables(1024, 1'b1);
        check_range("step_b_l25", ones_bl, 250, 262);
        check_range("step_b_r75", ones_br, 762, 774);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
